instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Sequential instruction supplier for the autoencoder datapath, directly upstream of the control unit (CU).
- Holds the program counter and reads 16-bit words ({opcode[15:12], f1[11:8], f2[7:4], f3[3:0]}) from a synchronous program memory.
- Buffers them in a 2-entry prefetch FIFO and presents them to the CU over a valid/ready handshake.
- Resolves JUMP and HALT opcodes locally, so the CU only ever sees datapath instructions.

Parameters:
- ADDR_W, 8, program memory address width; PC wraps modulo 2^ADDR_W.
- INSTR_W, 16, instruction width (fixed format above).
- JUMP_OP, 4'hE, opcode of an unconditional jump; target = word[ADDR_W-1:0].
- HALT_OP, 4'hF, opcode that ends the program.

Ports:
- clock, input, 1, single system clock, rising edge.
- reset, input, 1, asynchronous, active-high; clears all state.
- start, input, 1, one-cycle pulse; begins fetching at start_addr; honoured only in IDLE or HALTED.
- start_addr, input, ADDR_W, first program address.
- imem_rd_en, output, 1, program memory read strobe.
- imem_addr, output, ADDR_W, read address (the current PC when imem_rd_en=1).
- imem_rdata, input, INSTR_W, read data; valid exactly 1 cycle after imem_rd_en.
- instr, output, INSTR_W, FIFO head instruction to the CU.
- instr_valid, output, 1, instr holds a valid instruction.
- instr_ready, input, 1, CU accepts instr this cycle.
- busy, output, 1, high in FETCH or DRAIN.
- halted, output, 1, high in HALTED.
- pc, output, ADDR_W, current fetch PC (debug).

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; FIFO count=0; pend=0; squash=0.
  - pc=0, imem_rd_en=0, imem_addr=0, instr=0, instr_valid=0, busy=0, halted=0.
- Handshake:
  - pop = instr_valid & instr_ready.
  - instr and instr_valid are driven from FIFO head registers (no combinational path from imem_rdata).
  - instr must remain stable while instr_valid=1 and instr_ready=0.
- FSM states: IDLE, FETCH, DRAIN, HALTED.
  - IDLE/HALTED + start: pc<=start_addr, halted<=0, go to FETCH. start in any other state is ignored.
  - FETCH: issue a read (imem_rd_en=1, imem_addr=pc, pc<=pc+1 with wrap) when (count + pend - pop) <= 1. pend<=imem_rd_en.
  - This gives one instruction per cycle when the CU is always ready, and never overflows the FIFO.
- Return handling (cycle after a read, pend=1):
  - If squash=1: discard the word and clear squash.
  - Opcode JUMP_OP: word not enqueued; pc<=target; set squash<=1 if a read is issued this same cycle, else squash<=0. Stay in FETCH.
  - Opcode HALT_OP: word not enqueued; set squash as for JUMP; no further reads; go to DRAIN.
  - Any other opcode: enqueue.
  - Enqueue and pop in the same cycle: count unchanged, head advances.
- DRAIN: no reads; when count=0 and pend=0, go to HALTED.
- Boundaries:
  - FIFO full (count=2) with no pop: no read issued.
  - FIFO empty: instr_valid=0; instr holds its last value.
  - PC wraps from 2^ADDR_W-1 to 0.
  - JUMP to its own address loops forever, with no CU output and busy=1.
  - Reset mid-operation discards the FIFO contents and any in-flight read; data returning after reset is ignored.
  - An instruction accepted in the same cycle the FSM enters HALTED is legal.
- Latency: start to first instr_valid = 3 cycles (start registers, read issues, data enqueued, visible next edge).
  - JUMP bubble: 2 cycles.

Decomposition:
- Shared package (autoencoder defs): INSTR_W, opcode field slice [15:12], JUMP_OP, HALT_OP, FSM state encoding.
- One natural sub-module: fetch_fifo2, a 2-entry register FIFO with push/pop/count, head output, simultaneous push+pop.
- Sequencing and opcode decode stay in instr_fetch_unit.

Test Plan:
- Straight line: memory 0x00..0x03 = 16'h1123, 16'h2234, 16'h3345, 16'hF000; start_addr=0; instr_ready=1 → CU receives 1123, 2234, 3345 on consecutive cycles. First valid 3 cycles after start. halted=1 after the drain; HALT word is never presented.
- Backpressure: same program with instr_ready=0 for 10 cycles after first valid → instr holds 16'h1123. imem_rd_en issues at most 2 reads total. After release, the order is unchanged with no loss or duplicate.
- Jump: 0x10=16'h1111, 0x11=16'hE020, 0x12=16'h9999, 0x20=16'h2222, 0x21=16'hF000 → CU sees 1111 then 2222. 9999 is never presented even though its read was issued.
- Wrap: start_addr=8'hFE; words at FE, FF, 00 = 16'hA001, A002, A003; 01=16'hF000 → A001, A002, A003 in order; pc passes FF→00.
- Reset mid-run: assert reset while count=2 and pend=1 → all outputs 0 immediately (asynchronous). Data returning next cycle is ignored. A following start refetches correctly.
- start while busy: pulse start with start_addr=8'h40 during FETCH → ignored; the program continues from its current PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_fetch_unit_pkg                                            |
// | Brief    : Shared autoencoder definitions for the instruction fetch unit.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package instr_fetch_unit_pkg;

    localparam int unsigned c_ADDR_W  = 8;
    localparam int unsigned c_INSTR_W = 16;

    // Opcode field sits in the top nibble: {opcode, f1, f2, f3}
    localparam int unsigned c_OPC_HI = 15;
    localparam int unsigned c_OPC_LO = 12;

    localparam logic [3:0] c_JUMP_OP = 4'hE;
    localparam logic [3:0] c_HALT_OP = 4'hF;

    localparam int unsigned c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE   = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_FETCH  = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DRAIN  = 2'd2;
    localparam logic [c_STATE_W-1:0] c_ST_HALTED = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_fifo2                                                     |
// | Brief    : Two-entry register FIFO; head is entry 0, push+pop same cycle.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fetch_fifo2 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_data0;
    logic [WIDTH-1:0] r_data1;
    logic [1:0]       r_count;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    // Entry 0 is left untouched when the FIFO empties so the head holds its last value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_data0 <= i_push_data;
                    end else begin
                        r_data1 <= i_push_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_data0 <= r_data1;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_data0 <= i_push_data;
                    end else begin
                        r_data0 <= r_data1;
                        r_data1 <= i_push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_head  = r_data0;
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_fetch_unit                                                |
// | Brief    : PC sequencer with prefetch FIFO; resolves JUMP/HALT locally.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W  = c_ADDR_W,
    parameter int unsigned INSTR_W = c_INSTR_W,
    parameter logic [3:0]  JUMP_OP = c_JUMP_OP,
    parameter logic [3:0]  HALT_OP = c_HALT_OP
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_addr,
    output logic               imem_rd_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               busy,
    output logic               halted,
    output logic [ADDR_W-1:0]  pc
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_next;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    w_pc_next;
    logic                 r_pend;
    logic                 r_squash;
    logic                 w_squash_next;
    logic                 w_rd_en;
    logic                 w_push;
    logic                 w_pop;
    logic [1:0]           w_count;
    logic [2:0]           w_occ;
    logic [3:0]           w_opcode;
    logic                 w_live_ret;
    logic                 w_drained;

    assign w_pop      = instr_valid & instr_ready;
    assign w_opcode   = imem_rdata[c_OPC_HI:c_OPC_LO];
    assign w_live_ret = r_pend & ~r_squash;

    // Slots committed after this cycle: stored + in flight - leaving
    assign w_occ     = {1'b0, w_count} + {2'b00, r_pend} - {2'b00, w_pop};
    assign w_drained = ~r_pend && ((w_count == 2'd0) || ((w_count == 2'd1) && w_pop));

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_squash_next = r_squash;
        w_rd_en       = 1'b0;
        w_push        = 1'b0;

        if (r_pend && r_squash) begin
            w_squash_next = 1'b0;
        end

        case (r_state)
            c_ST_IDLE, c_ST_HALTED: begin
                if (start) begin
                    w_state_next = c_ST_FETCH;
                    w_pc_next    = start_addr;
                end
            end
            c_ST_FETCH: begin
                w_rd_en = (w_occ <= 3'd1);
                if (w_rd_en) begin
                    w_pc_next = r_pc + ADDR_W'(1);
                end
                // A read issued alongside a JUMP/HALT fetched the wrong path
                if (w_live_ret) begin
                    if (w_opcode == JUMP_OP) begin
                        w_pc_next     = imem_rdata[ADDR_W-1:0];
                        w_squash_next = w_rd_en;
                    end else if (w_opcode == HALT_OP) begin
                        w_squash_next = w_rd_en;
                        w_state_next  = c_ST_DRAIN;
                    end else begin
                        w_push = 1'b1;
                    end
                end
            end
            c_ST_DRAIN: begin
                if (w_drained) begin
                    w_state_next = c_ST_HALTED;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_pc     <= '0;
            r_pend   <= 1'b0;
            r_squash <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_pend   <= w_rd_en;
            r_squash <= w_squash_next;
        end
    end

    fetch_fifo2 #(
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk         (clock),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data (imem_rdata),
        .i_pop       (w_pop),
        .o_head      (instr),
        .o_valid     (instr_valid),
        .o_count     (w_count)
    );

    assign imem_rd_en = w_rd_en;
    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign busy       = (r_state == c_ST_FETCH) || (r_state == c_ST_DRAIN);
    assign halted     = (r_state == c_ST_HALTED);

endmodule
`default_nettype wire
